modmul_sequencer: RTL and testbench
===================================

MODMUL_SEQUENCER -- requirements
Module: modmul_sequencer

Interface
REQ-001 SKIP_LEADING_ZEROS, default 1: when 1, iteration begins at the most-significant set bit of B; when 0, it always begins at bit 63.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 start_i  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 clear_i  input  1  synchronous abort of the current operation.
REQ-006 a_i / b_i / p_i  input  64 each  operands; captured on accepted start. Result is (A*B) mod P.
REQ-007 busy_o  output  1  high from the cycle after accepted start until done_o.
REQ-008 done_o  output  1  single-cycle completion pulse.
REQ-009 err_o  output  1  operand error flag; valid with done_o and held until the next accepted start.
REQ-010 result_o  output  64  product; valid with done_o and held until the next accepted start.
REQ-011 dbl_start_o  output  1  doubling request; dbl_a_o / dbl_p_o  output  64 each  doubling operands.
REQ-012 dbl_finish_i  input  1  doubling done; dbl_result_i  input  64  (2*dbl_a_o) mod dbl_p_o.
REQ-013 add_start_o  output  1  addition request; add_a_o / add_b_o / add_p_o  output  64 each  addition operands.
REQ-014 add_finish_i  input  1  addition done; add_result_i  input  64  (add_a_o+add_b_o) mod add_p_o.

Function
REQ-015 FSM states SHALL be: IDLE, CHECK, DBL, ADD, NEXT, DONE.
REQ-016 IDLE with start_i=1: latch A, B, P; clear accumulator R to 0; go to CHECK. start_i outside IDLE SHALL be ignored.
REQ-017 CHECK: if P==0 or A>=P, go to DONE with err_o=1 and result 0, issuing no unit requests.
REQ-018 CHECK: if B==0, go to DONE with result 0 and err_o=0, issuing no unit requests.
REQ-019 CHECK otherwise: set bit index i to msb(B) (SKIP_LEADING_ZEROS=1) or 63 (SKIP_LEADING_ZEROS=0); go to DBL.
REQ-020 DBL: hold dbl_start_o=1, dbl_a_o=R, dbl_p_o=P.
REQ-021 DBL: on dbl_finish_i=1, R<=dbl_result_i and dbl_start_o drops the next cycle; go to ADD if B[i]=1, else NEXT.
REQ-022 ADD: hold add_start_o=1, add_a_o=R, add_b_o=A, add_p_o=P.
REQ-023 ADD: on add_finish_i=1, R<=add_result_i; go to NEXT.
REQ-024 NEXT: if i==0, go to DONE; else i<=i-1 and go to DBL. The index SHALL never wrap below 0.
REQ-025 DONE: done_o=1 for one cycle; result_o<=R; return to IDLE.
REQ-026 Request operands SHALL stay stable while their start is high; finish inputs SHALL be ignored outside the matching wait state.
REQ-027 Requests SHALL be exclusive: dbl_start_o and add_start_o are never high together.
REQ-028 Each request start SHALL drop for at least one cycle between consecutive handshakes.
REQ-029 With units that finish one cycle after start, each handshake costs 2 cycles.
REQ-030 clear_i=1 in any non-IDLE state: go to IDLE the next cycle; deassert all starts; done_o stays 0; result_o/err_o unchanged.
REQ-031 clear_i together with start_i in IDLE: the clear wins and the start is dropped.
REQ-032 Invariant: R<P at all times (a precondition for the units).

Reset
REQ-033 On rst_ni=0, asynchronously: state IDLE; busy_o, done_o, err_o, dbl_start_o, add_start_o = 0; result_o, all operand outputs, R and i = 0.
REQ-034 Reset mid-operation SHALL abort with no done_o pulse.
REQ-035 The first start after reset release SHALL be accepted normally.

Verification
REQ-036 A=3, B=5, P=7, SKIP=1 -> done_o with result_o=1, err_o=0; exactly 3 dbl handshakes and 2 add handshakes.
REQ-037 A=P-1, B=0xFFFFFFFFFFFFFFFF, P=0xFFFFFFFFFFFFFFC5 -> result_o=0xFFFFFFFFFFFFFF8B; 64 doubling and 64 add handshakes.
REQ-038 A=7, P=7 -> err_o=1, result_o=0, done_o 2 cycles after start; dbl_start_o/add_start_o never asserted. Also B=0 -> result_o=0, err_o=0.
REQ-039 Units with random 1-5 cycle finish delay, random operands, SKIP=0 and 1 -> result_o equals the reference (A*B) mod P; operands stable while start is high.
REQ-040 clear_i pulsed during DBL of A=3, B=5, P=7 -> IDLE next cycle, no done_o, prior result_o kept; a new start completes correctly.
REQ-041 Two further checks: start_i while busy -> ignored, in-flight result unaffected; rst_ni pulsed mid-ADD -> all outputs 0 immediately, no done_o.

Source files
------------

// File: rtl/modmul_sequencer_if.sv
// Handshake bundle for the modular multiply sequencer:
// host request/result plus the doubling and addition unit links.
interface modmul_sequencer_if;
  logic        start_i;
  logic        clear_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic [63:0] p_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [63:0] result_o;
  logic        dbl_start_o;
  logic [63:0] dbl_a_o;
  logic [63:0] dbl_p_o;
  logic        dbl_finish_i;
  logic [63:0] dbl_result_i;
  logic        add_start_o;
  logic [63:0] add_a_o;
  logic [63:0] add_b_o;
  logic [63:0] add_p_o;
  logic        add_finish_i;
  logic [63:0] add_result_i;

  modport master (
    output start_i, clear_i, a_i, b_i, p_i,
    output dbl_finish_i, dbl_result_i,
    output add_finish_i, add_result_i,
    input  busy_o, done_o, err_o, result_o,
    input  dbl_start_o, dbl_a_o, dbl_p_o,
    input  add_start_o, add_a_o, add_b_o, add_p_o
  );

  modport slave (
    input  start_i, clear_i, a_i, b_i, p_i,
    input  dbl_finish_i, dbl_result_i,
    input  add_finish_i, add_result_i,
    output busy_o, done_o, err_o, result_o,
    output dbl_start_o, dbl_a_o, dbl_p_o,
    output add_start_o, add_a_o, add_b_o, add_p_o
  );
endinterface

// File: rtl/modmul_sequencer.sv
// Double-and-add (A*B) mod P sequencer, MSB first over B,
// driving external modular doubling and addition units.
module modmul_sequencer #(
  parameter bit SKIP_LEADING_ZEROS = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  modmul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DBL, ADD, NEXT, DONE
  } state_e;

  state_e      state_q;
  logic [63:0] a_q, b_q, p_q, r_q, res_q;
  logic [5:0]  idx_q, idx_d;
  logic        busy_q, done_q, err_q;
  logic        dbl_start_q, add_start_q;
  logic [63:0] dbl_a_q, dbl_p_q;
  logic [63:0] add_a_q, add_b_q, add_p_q;

  always_comb begin
    idx_d = 6'd63;
    if (SKIP_LEADING_ZEROS) begin
      idx_d = '0;
      for (int k = 0; k < 64; k++)
        if (b_q[k]) idx_d = 6'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      r_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dbl_start_q <= 1'b0;
      dbl_a_q     <= '0;
      dbl_p_q     <= '0;
      add_start_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort wins over everything, including a start in IDLE.
      if (bus.clear_i) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        dbl_start_q <= 1'b0;
        add_start_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start_i) begin
              a_q     <= bus.a_i;
              b_q     <= bus.b_i;
              p_q     <= bus.p_i;
              r_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            if (p_q == '0 || a_q >= p_q || b_q == '0) begin
              err_q   <= (p_q == '0 || a_q >= p_q);
              res_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q       <= idx_d;
              dbl_start_q <= 1'b1;
              dbl_a_q     <= r_q;
              dbl_p_q     <= p_q;
              state_q     <= DBL;
            end
          end
          DBL: begin
            if (bus.dbl_finish_i) begin
              r_q         <= bus.dbl_result_i;
              dbl_start_q <= 1'b0;
              if (b_q[idx_q]) begin
                add_start_q <= 1'b1;
                add_a_q     <= bus.dbl_result_i;
                add_b_q     <= a_q;
                add_p_q     <= p_q;
                state_q     <= ADD;
              end else begin
                state_q <= NEXT;
              end
            end
          end
          ADD: begin
            if (bus.add_finish_i) begin
              r_q         <= bus.add_result_i;
              add_start_q <= 1'b0;
              state_q     <= NEXT;
            end
          end
          NEXT: begin
            if (idx_q == '0) begin
              res_q   <= r_q;
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q       <= idx_q - 6'd1;
              dbl_start_q <= 1'b1;
              dbl_a_q     <= r_q;
              dbl_p_q     <= p_q;
              state_q     <= DBL;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.result_o    = res_q;
  assign bus.dbl_start_o = dbl_start_q;
  assign bus.dbl_a_o     = dbl_a_q;
  assign bus.dbl_p_o     = dbl_p_q;
  assign bus.add_start_o = add_start_q;
  assign bus.add_a_o     = add_a_q;
  assign bus.add_b_o     = add_b_q;
  assign bus.add_p_o     = add_p_q;

endmodule

// File: tb/tb_modmul_sequencer.sv
// Bench for modmul_sequencer: two DUTs (skip on / skip off) share
// stimulus; behavioural unit models and an arithmetic reference.
module tb_modmul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] a = '0, b = '0, p = '0;
  int          nchk = 0;
  int          nfail = 0;
  int          dly_max = 1;

  always #5 clk = ~clk;

  modmul_sequencer_if ifs1 ();
  modmul_sequencer_if ifs0 ();

  assign ifs1.start_i = start;
  assign ifs1.clear_i = clear;
  assign ifs1.a_i = a;
  assign ifs1.b_i = b;
  assign ifs1.p_i = p;
  assign ifs0.start_i = start;
  assign ifs0.clear_i = clear;
  assign ifs0.a_i = a;
  assign ifs0.b_i = b;
  assign ifs0.p_i = p;

  modmul_sequencer #(.SKIP_LEADING_ZEROS(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifs1.slave)
  );
  modmul_sequencer #(.SKIP_LEADING_ZEROS(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifs0.slave)
  );

  // index 0 = skip DUT, 1 = no-skip DUT; units: 2*d dbl, 2*d+1 add
  logic        o_busy[2], o_done[2], o_err[2], o_dbls[2], o_adds[2];
  logic [63:0] o_res[2];
  logic [319:0] o_ops[2];
  logic        us[4], uf[4];
  logic [63:0] ua[4], ub[4], up[4], ur[4];

  assign o_busy[0] = ifs1.busy_o;
  assign o_done[0] = ifs1.done_o;
  assign o_err[0]  = ifs1.err_o;
  assign o_res[0]  = ifs1.result_o;
  assign o_dbls[0] = ifs1.dbl_start_o;
  assign o_adds[0] = ifs1.add_start_o;
  assign o_ops[0]  = {ifs1.dbl_a_o, ifs1.dbl_p_o, ifs1.add_a_o,
                      ifs1.add_b_o, ifs1.add_p_o};
  assign o_busy[1] = ifs0.busy_o;
  assign o_done[1] = ifs0.done_o;
  assign o_err[1]  = ifs0.err_o;
  assign o_res[1]  = ifs0.result_o;
  assign o_dbls[1] = ifs0.dbl_start_o;
  assign o_adds[1] = ifs0.add_start_o;
  assign o_ops[1]  = {ifs0.dbl_a_o, ifs0.dbl_p_o, ifs0.add_a_o,
                      ifs0.add_b_o, ifs0.add_p_o};

  assign us[0] = ifs1.dbl_start_o;
  assign ua[0] = ifs1.dbl_a_o;
  assign ub[0] = ifs1.dbl_a_o;
  assign up[0] = ifs1.dbl_p_o;
  assign us[1] = ifs1.add_start_o;
  assign ua[1] = ifs1.add_a_o;
  assign ub[1] = ifs1.add_b_o;
  assign up[1] = ifs1.add_p_o;
  assign us[2] = ifs0.dbl_start_o;
  assign ua[2] = ifs0.dbl_a_o;
  assign ub[2] = ifs0.dbl_a_o;
  assign up[2] = ifs0.dbl_p_o;
  assign us[3] = ifs0.add_start_o;
  assign ua[3] = ifs0.add_a_o;
  assign ub[3] = ifs0.add_b_o;
  assign up[3] = ifs0.add_p_o;

  assign ifs1.dbl_finish_i = uf[0];
  assign ifs1.dbl_result_i = ur[0];
  assign ifs1.add_finish_i = uf[1];
  assign ifs1.add_result_i = ur[1];
  assign ifs0.dbl_finish_i = uf[2];
  assign ifs0.dbl_result_i = ur[2];
  assign ifs0.add_finish_i = uf[3];
  assign ifs0.add_result_i = ur[3];

  function automatic logic [63:0] madd(input logic [63:0] x, y, m);
    logic [64:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (m == '0) ? '0 : 64'(s % {1'b0, m});
  endfunction

  int cnt[4], dly[4], hs[4], sc[4];
  logic ps[4], gap[4];
  logic [63:0] pa[4], pb[4], pp[4];
  int stab_err = 0, gap_err = 0, excl_err = 0, inv_err = 0;
  int dc[2];

  initial begin
    for (int i = 0; i < 4; i++) begin
      hs[i] = 0; sc[i] = 0; uf[i] = 1'b0; ur[i] = '0;
      cnt[i] = 0; dly[i] = 1; ps[i] = 1'b0; gap[i] = 1'b0;
      pa[i] = '0; pb[i] = '0; pp[i] = '0;
    end
    dc[0] = 0; dc[1] = 0;
  end

  // Arithmetic units with programmable finish latency, plus monitors.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (us[i]) sc[i] <= sc[i] + 1;
      if (!rst_n) begin
        uf[i] <= 1'b0; cnt[i] <= 0; ps[i] <= 1'b0; gap[i] <= 1'b0;
      end else begin
        uf[i] <= 1'b0;
        if (us[i] && !uf[i]) begin
          if (cnt[i] + 1 >= dly[i]) begin
            uf[i]  <= 1'b1;
            ur[i]  <= madd(ua[i], ub[i], up[i]);
            cnt[i] <= 0;
            hs[i]  <= hs[i] + 1;
            dly[i] <= int'($urandom_range(dly_max, 1));
          end else begin
            cnt[i] <= cnt[i] + 1;
          end
        end else if (!us[i]) begin
          cnt[i] <= 0;
        end
        if (us[i] && ps[i] &&
            {ua[i], ub[i], up[i]} != {pa[i], pb[i], pp[i]})
          stab_err <= stab_err + 1;
        if (us[i] && (ua[i] >= up[i] || ub[i] >= up[i]))
          inv_err <= inv_err + 1;
        if (gap[i] && us[i]) gap_err <= gap_err + 1;
        gap[i] <= uf[i];
        ps[i]  <= us[i];
        pa[i]  <= ua[i];
        pb[i]  <= ub[i];
        pp[i]  <= up[i];
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (o_dbls[d] && o_adds[d]) excl_err <= excl_err + 1;
      if (o_done[d]) dc[d] <= dc[d] + 1;
    end
  end

  task automatic ref_model(input logic [63:0] ra, rb, rp,
                           input bit skip,
                           output logic [63:0] r, output bit e,
                           output int nd, output int na,
                           output int lat);
    logic [127:0] prod;
    int msb;
    e = (rp == '0) || (ra >= rp);
    r = '0; nd = 0; na = 0; lat = 2;
    if (!e && rb != '0) begin
      prod = {64'b0, ra} * {64'b0, rb};
      r = 64'(prod % {64'b0, rp});
      msb = 0;
      for (int k = 0; k < 64; k++) begin
        if (rb[k]) begin
          msb = k;
          na++;
        end
      end
      nd = skip ? msb + 1 : 64;
      lat = 2 + 3 * nd + 2 * na;
    end
  endtask

  task automatic issue(input logic [63:0] ia, ib, ip);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; p = ip;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit to, output int l0, output int l1);
    int k;
    l0 = -1; l1 = -1; k = 1;
    while (k < 4000 && (l0 < 0 || l1 < 0)) begin
      if (l0 < 0 && o_done[0]) l0 = k;
      if (l1 < 0 && o_done[1]) l1 = k;
      if (l0 < 0 || l1 < 0) begin
        @(negedge clk);
        k++;
      end
    end
    to = (l0 < 0 || l1 < 0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [63:0] ia, ib, ip,
                        output bit to, output int l0, output int l1,
                        output logic [1:0] bz);
    issue(ia, ib, ip);
    bz = {o_busy[1], o_busy[0]};
    wait_done(to, l0, l1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({o_busy[d], o_done[d], o_err[d], o_dbls[d], o_adds[d]}
          !== 5'b0) begin
        nfail++;
        $display("FAIL reset_flags dut%0d got %b want 00000", d,
                 {o_busy[d], o_done[d], o_err[d], o_dbls[d], o_adds[d]});
      end
      nchk++;
      if (o_res[d] !== 64'h0) begin
        nfail++;
        $display("FAIL reset_result dut%0d got %h want 0", d, o_res[d]);
      end
      nchk++;
      if (o_ops[d] !== 320'h0) begin
        nfail++;
        $display("FAIL reset_operands dut%0d got nonzero want 0", d);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to; int l[2]; logic [1:0] bz; int h0[4];
    logic [63:0] r; bit e; int nd, na, lat;
    dly_max = 1;
    for (int i = 0; i < 4; i++) h0[i] = hs[i];
    run_op(64'd3, 64'd5, 64'd7, to, l[0], l[1], bz);
    nchk++;
    if (to !== 1'b0 || bz !== 2'b11) begin
      nfail++;
      $display("FAIL basic_busy timeout=%0d busy=%b want 0/11", to, bz);
    end
    for (int d = 0; d < 2; d++) begin
      ref_model(64'd3, 64'd5, 64'd7, d == 0, r, e, nd, na, lat);
      nchk++;
      if (o_res[d] !== 64'd1 || o_err[d] !== 1'b0) begin
        nfail++;
        $display("FAIL basic_result dut%0d got %h/%b want 1/0",
                 d, o_res[d], o_err[d]);
      end
      nchk++;
      if (hs[2*d] - h0[2*d] != nd || hs[2*d+1] - h0[2*d+1] != 2) begin
        nfail++;
        $display("FAIL basic_hs dut%0d got %0d/%0d want %0d/2", d,
                 hs[2*d] - h0[2*d], hs[2*d+1] - h0[2*d+1], nd);
      end
      nchk++;
      if (l[d] != lat) begin
        nfail++;
        $display("FAIL basic_latency dut%0d got %0d want %0d",
                 d, l[d], lat);
      end
    end
  endtask

  task automatic test_errors;
    bit to; int l[2]; logic [1:0] bz; int s0[4];
    dly_max = 1;
    for (int i = 0; i < 4; i++) s0[i] = sc[i];
    run_op(64'd7, 64'd9, 64'd7, to, l[0], l[1], bz);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (o_err[d] !== 1'b1 || o_res[d] !== 64'h0 || l[d] != 2) begin
        nfail++;
        $display("FAIL err_a_ge_p dut%0d got %b/%h/%0d want 1/0/2",
                 d, o_err[d], o_res[d], l[d]);
      end
    end
    run_op(64'd5, 64'd9, 64'd0, to, l[0], l[1], bz);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (o_err[d] !== 1'b1 || o_res[d] !== 64'h0) begin
        nfail++;
        $display("FAIL err_p_zero dut%0d got %b/%h want 1/0",
                 d, o_err[d], o_res[d]);
      end
    end
    nchk++;
    if (sc[0] != s0[0] || sc[1] != s0[1] ||
        sc[2] != s0[2] || sc[3] != s0[3]) begin
      nfail++;
      $display("FAIL err_no_requests got start cycles want none");
    end
    run_op(64'd3, 64'd5, 64'd7, to, l[0], l[1], bz);
    run_op(64'd4, 64'd0, 64'd7, to, l[0], l[1], bz);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (o_err[d] !== 1'b0 || o_res[d] !== 64'h0 || l[d] != 2) begin
        nfail++;
        $display("FAIL b_zero dut%0d got %b/%h/%0d want 0/0/2",
                 d, o_err[d], o_res[d], l[d]);
      end
    end
  endtask

  task automatic test_max;
    bit to; int l[2]; logic [1:0] bz; int h0[4];
    logic [63:0] pm;
    pm = 64'hFFFFFFFFFFFFFFC5;
    for (int i = 0; i < 4; i++) h0[i] = hs[i];
    run_op(pm - 64'd1, '1, pm, to, l[0], l[1], bz);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (o_res[d] !== 64'hFFFFFFFFFFFFFF8B || o_err[d] !== 1'b0) begin
        nfail++;
        $display("FAIL max_result dut%0d got %h want ffffffffffffff8b",
                 d, o_res[d]);
      end
      nchk++;
      if (hs[2*d] - h0[2*d] != 64 || hs[2*d+1] - h0[2*d+1] != 64) begin
        nfail++;
        $display("FAIL max_hs dut%0d got %0d/%0d want 64/64", d,
                 hs[2*d] - h0[2*d], hs[2*d+1] - h0[2*d+1]);
      end
    end
  endtask

  task automatic test_random;
    bit to; int l[2]; logic [1:0] bz; int h0[4];
    logic [63:0] ra, rb, rp, r; bit e; int nd, na, lat;
    dly_max = 5;
    for (int n = 0; n < 8; n++) begin
      rp = {$urandom, $urandom};
      if (rp == '0) rp = 64'd1;
      if (n == 1) rp = 64'd1000003;
      ra = (n == 3) ? rp : {$urandom, $urandom} % rp;
      rb = {$urandom, $urandom} >> $urandom_range(63, 0);
      for (int i = 0; i < 4; i++) h0[i] = hs[i];
      run_op(ra, rb, rp, to, l[0], l[1], bz);
      nchk++;
      if (to) begin
        nfail++;
        $display("FAIL rand_timeout op%0d got timeout want done", n);
      end
      for (int d = 0; d < 2; d++) begin
        ref_model(ra, rb, rp, d == 0, r, e, nd, na, lat);
        nchk++;
        if (o_res[d] !== r || o_err[d] !== e) begin
          nfail++;
          $display("FAIL rand_result op%0d dut%0d got %h/%b want %h/%b",
                   n, d, o_res[d], o_err[d], r, e);
        end
        nchk++;
        if (hs[2*d] - h0[2*d] != nd || hs[2*d+1] - h0[2*d+1] != na) begin
          nfail++;
          $display("FAIL rand_hs op%0d dut%0d got %0d/%0d want %0d/%0d",
                   n, d, hs[2*d] - h0[2*d], hs[2*d+1] - h0[2*d+1],
                   nd, na);
        end
      end
    end
    nchk++;
    if (stab_err != 0 || inv_err != 0) begin
      nfail++;
      $display("FAIL operand_stability got %0d/%0d events want 0/0",
               stab_err, inv_err);
    end
    nchk++;
    if (gap_err != 0 || excl_err != 0) begin
      nfail++;
      $display("FAIL start_protocol got gap=%0d excl=%0d want 0/0",
               gap_err, excl_err);
    end
  endtask

  task automatic test_clear;
    bit to; int l[2]; logic [1:0] bz; logic [63:0] pr[2];
    int k, d0[2];
    dly_max = 1;
    pr[0] = o_res[0]; pr[1] = o_res[1];
    issue(64'd3, 64'd5, 64'd7);
    k = 0;
    while (!o_dbls[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    nchk++;
    if (!o_dbls[0]) begin
      nfail++;
      $display("FAIL clear_reach_dbl got no dbl_start want dbl_start");
    end
    d0[0] = dc[0]; d0[1] = dc[1];
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({o_busy[d], o_dbls[d], o_adds[d], o_done[d]} !== 4'b0 ||
          o_res[d] !== pr[d]) begin
        nfail++;
        $display("FAIL clear_abort dut%0d got %b/%h want 0000/%h", d,
                 {o_busy[d], o_dbls[d], o_adds[d], o_done[d]},
                 o_res[d], pr[d]);
      end
    end
    repeat (10) @(negedge clk);
    nchk++;
    if (dc[0] != d0[0] || dc[1] != d0[1]) begin
      nfail++;
      $display("FAIL clear_no_done got %0d/%0d extra pulses want 0",
               dc[0] - d0[0], dc[1] - d0[1]);
    end
    run_op(64'd3, 64'd5, 64'd7, to, l[0], l[1], bz);
    nchk++;
    if (to || o_res[0] !== 64'd1 || o_res[1] !== 64'd1) begin
      nfail++;
      $display("FAIL clear_restart got %h/%h want 1/1",
               o_res[0], o_res[1]);
    end
  endtask

  task automatic test_start_busy;
    bit to; int l[2]; int h0[4], d0[2];
    dly_max = 1;
    for (int i = 0; i < 4; i++) h0[i] = hs[i];
    d0[0] = dc[0]; d0[1] = dc[1];
    issue(64'd3, 64'd5, 64'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 64'd2; b = 64'd3; p = 64'd11;
    @(negedge clk);
    start = 1'b0;
    wait_done(to, l[0], l[1]);
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (to || o_res[d] !== 64'd1 || dc[d] - d0[d] != 1) begin
        nfail++;
        $display("FAIL busy_start dut%0d got %h/%0d want 1/1 done",
                 d, o_res[d], dc[d] - d0[d]);
      end
    end
    nchk++;
    if (hs[0] - h0[0] != 3 || hs[1] - h0[1] != 2) begin
      nfail++;
      $display("FAIL busy_start_hs got %0d/%0d want 3/2",
               hs[0] - h0[0], hs[1] - h0[1]);
    end
  endtask

  task automatic test_reset_mid;
    bit to; int l[2]; logic [1:0] bz; int k, d0[2];
    dly_max = 1;
    issue(64'd3, 64'd5, 64'd7);
    k = 0;
    while (!o_adds[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    nchk++;
    if (!o_adds[0]) begin
      nfail++;
      $display("FAIL rst_reach_add got no add_start want add_start");
    end
    d0[0] = dc[0]; d0[1] = dc[1];
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({o_busy[d], o_done[d], o_err[d], o_dbls[d], o_adds[d]}
          !== 5'b0 || o_res[d] !== 64'h0 || o_ops[d] !== 320'h0) begin
        nfail++;
        $display("FAIL rst_mid dut%0d got flags %b res %h want all 0",
                 d, {o_busy[d], o_done[d], o_err[d], o_dbls[d],
                 o_adds[d]}, o_res[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    nchk++;
    if (dc[0] != d0[0] || dc[1] != d0[1]) begin
      nfail++;
      $display("FAIL rst_no_done got %0d/%0d pulses want 0",
               dc[0] - d0[0], dc[1] - d0[1]);
    end
    run_op(64'd3, 64'd5, 64'd7, to, l[0], l[1], bz);
    nchk++;
    if (to || bz !== 2'b11 || o_res[0] !== 64'd1 ||
        o_res[1] !== 64'd1) begin
      nfail++;
      $display("FAIL rst_first_start got %b %h/%h want 11 1/1",
               bz, o_res[0], o_res[1]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_errors;
    test_max;
    test_random;
    test_clear;
    test_start_busy;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
